// File: rtl/pass_entry_pkg.sv
// -----------------------------------------------------------------------------
// pass_entry_pkg
//   Shared definitions for the password-entry front end and the lock FSM:
//   FSM state encoding, code width and the default unlock code.
// -----------------------------------------------------------------------------
package pass_entry_pkg;

  // Width of the code presented to the lock FSM.
  localparam int PASS_W = 4;

  // Factory unlock code used by the lock FSM.
  localparam logic [PASS_W-1:0] DEFAULT_CODE = 4'b1001;

  // Binary 3-bit state encoding; codes 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    WAIT_REL = 3'd2,
    DB_REL   = 3'd3,
    HOLDOFF  = 3'd4
  } state_t;

endpackage

// File: rtl/pass_entry_if.sv
// -----------------------------------------------------------------------------
// pass_entry_if
//   Groups the raw button/switch inputs and the outputs presented to the lock
//   FSM.
//   master : drives btn_raw/sw_raw, observes pass_data/confirm/busy
//   slave  : the pass_entry block itself
//   Signals:
//     btn_raw    raw confirm button, asynchronous, active-high, may bounce
//     sw_raw     raw code switches, asynchronous
//     pass_data  captured code, registered
//     confirm    one-cycle pulse coincident with new pass_data
//     busy       high whenever the entry FSM is not idle
// -----------------------------------------------------------------------------
interface pass_entry_if;
  import pass_entry_pkg::*;

  logic              btn_raw;
  logic [PASS_W-1:0] sw_raw;
  logic [PASS_W-1:0] pass_data;
  logic              confirm;
  logic              busy;

  modport master (
    output btn_raw, sw_raw,
    input  pass_data, confirm, busy
  );

  modport slave (
    input  btn_raw, sw_raw,
    output pass_data, confirm, busy
  );

endinterface

// File: rtl/pass_entry_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for asynchronous level inputs.
//   Ports:
//     clk  in          system clock, rising edge
//     rst  in          asynchronous reset, active-low; clears both stages to 0
//     d    in  WIDTH   asynchronous input bits
//     q    out WIDTH   synchronised bits, two clk edges of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make meta and q sample together on the
  // edge, giving two real flop stages; blocking here would collapse them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pass_entry.sv
// -----------------------------------------------------------------------------
// pass_entry
//   Front end for the password lock FSM. Synchronises and debounces the raw
//   confirm button and code switches, captures the code on an accepted press
//   and emits a single-cycle confirm pulse. After each debounced release a
//   hold-off window ignores further presses.
//   Parameters:
//     DEBOUNCE_CYCLES  cycles btn must be stable on press and release (>=1)
//     HOLDOFF_CYCLES   cycles presses are ignored after release (0 = none)
//     CNT_W            width of the shared debounce/hold-off counter
//   Ports:
//     clk   in     system clock, rising edge
//     rst   in     asynchronous reset, active-low
//     bus   slave  btn_raw/sw_raw in, pass_data/confirm/busy out
// -----------------------------------------------------------------------------
module pass_entry
  import pass_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic          clk,
  input  logic          rst,
  pass_entry_if.slave   bus
);

  // Terminal counts; hold-off terminal is unused when HOLDOFF_CYCLES == 0.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HO_LAST =
    CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  // ---------------------------------------------------------------------------
  // Input synchronisation: button and switches share one synchroniser so the
  // captured code is aligned with the debounced button.
  // ---------------------------------------------------------------------------
  logic [PASS_W:0]   sync_q;
  logic              btn_s;
  logic [PASS_W-1:0] sw_s;

  sync_2ff #(
    .WIDTH (PASS_W + 1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bus.btn_raw, bus.sw_raw}),
    .q   (sync_q)
  );

  assign btn_s = sync_q[PASS_W];
  assign sw_s  = sync_q[PASS_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM state and shared counter
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. Any state change clears the counter.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a
    // missed branch would infer a latch.
    state_next = state;
    cnt_next   = cnt;

    case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = DB_PRESS;
        end
      end

      DB_PRESS: begin
        if (!btn_s) begin
          state_next = IDLE;        // press bounce rejected, no pulse
        end else if (cnt == DB_LAST) begin
          state_next = WAIT_REL;    // press accepted
        end else begin
          cnt_next = cnt_inc;
        end
      end

      WAIT_REL: begin
        // A held button stays here; it can never re-trigger.
        if (!btn_s) begin
          state_next = DB_REL;
        end
      end

      DB_REL: begin
        if (btn_s) begin
          state_next = WAIT_REL;    // release bounce
        end else if (cnt == DB_LAST) begin
          state_next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      HOLDOFF: begin
        // Button deliberately ignored for the whole window.
        if (cnt == HO_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = IDLE;          // unused encodings recover
      end
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (combinational) feeding registered outputs, so confirm,
  // pass_data and busy all change on the same edge as the state.
  // ---------------------------------------------------------------------------
  logic accept;
  logic busy_next;

  always_comb begin
    accept    = (state == DB_PRESS) && btn_s && (cnt == DB_LAST);
    busy_next = (state_next != IDLE);
  end

  logic [PASS_W-1:0] pass_q;
  logic              confirm_q;
  logic              busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_q    <= '0;
      confirm_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      confirm_q <= accept;
      busy_q    <= busy_next;
      if (accept) begin
        pass_q <= sw_s;             // code only moves on an accepted press
      end
    end
  end

  assign bus.pass_data = pass_q;
  assign bus.confirm   = confirm_q;
  assign bus.busy      = busy_q;

endmodule
